// File: rtl/mem_stage_byte_ram.sv
// RISC-V MEM stage that runs loads/stores one byte per divider step over a
// byte-wide synchronous-read RAM, sharing the port with instruction fetch.
module mem_stage_byte_ram #(
  parameter int STEP_DIV = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        aluop_EXMEM_i,
  input  logic              wreg_EXMEM_i,
  input  logic [4:0]        waddr_EXMEM_i,
  input  logic [31:0]       alurslt_EXMEM_i,
  input  logic [31:0]       SdataBoffset_EXMEM_i,
  input  logic              if_re_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_grant_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] addr_RAM_o,
  output logic              wr_RAM_o,
  output logic [7:0]        wdata_RAM_o,
  input  logic [7:0]        rdata_RAM_i,
  output logic              wreg_MEMWB_o,
  output logic [4:0]        waddr_MEMWB_o,
  output logic [31:0]       wdata_MEMWB_o
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam int         CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  // With a one-cycle step the read byte arrives a step late, so loads get a trailing step.
  localparam bit EXTRA = (STEP_DIV == 1);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
      OP_LW, OP_SW:         op_bytes = 3'd4;
      default:              op_bytes = 3'd0;
    endcase
  endfunction

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   base_q, base_d, sdata_q, sdata_d, word_q, word_d;
  logic          wreg_q, wreg_d;
  logic [4:0]    waddr_q, waddr_d;
  logic          wreg_mw_q, wreg_mw_d;
  logic [4:0]    waddr_mw_q, waddr_mw_d;
  logic [31:0]   wdata_mw_q, wdata_mw_d;

  logic          start, busy, active, step_end, last, cur_store, samp_en, cur_wreg;
  logic [3:0]    cur_op;
  logic [31:0]   cur_base, cur_sdata, cur_word, word_new, load_val;
  logic [4:0]    cur_waddr;
  logic [CW-1:0] cur_cnt;
  logic [2:0]    cur_idx, n_steps;
  logic [1:0]    lane;

  always_comb begin
    start     = rst && (state_q == S_IDLE) && (op_bytes(aluop_EXMEM_i) != 3'd0);
    busy      = rst && (state_q == S_ACCESS);
    active    = start || busy;
    // In the start cycle the access runs straight off the EX/MEM inputs.
    cur_op    = busy ? op_q    : aluop_EXMEM_i;
    cur_base  = busy ? base_q  : alurslt_EXMEM_i;
    cur_sdata = busy ? sdata_q : SdataBoffset_EXMEM_i;
    cur_wreg  = busy ? wreg_q  : wreg_EXMEM_i;
    cur_waddr = busy ? waddr_q : waddr_EXMEM_i;
    cur_cnt   = busy ? cnt_q   : '0;
    cur_idx   = busy ? idx_q   : 3'd0;
    cur_word  = busy ? word_q  : 32'd0;
    cur_store = (cur_op == OP_SB) || (cur_op == OP_SH) || (cur_op == OP_SW);
    n_steps   = op_bytes(cur_op) + {2'b00, (EXTRA && !cur_store)};
    step_end  = (cur_cnt == CNT_LAST);
    last      = active && step_end && (cur_idx == n_steps - 3'd1);
    stall_o   = active && !last;

    if (EXTRA) begin
      samp_en = step_end && !cur_store && (cur_idx != 3'd0);
      lane    = 2'(cur_idx - 3'd1);
    end else begin
      samp_en = step_end && !cur_store;
      lane    = cur_idx[1:0];
    end
    word_new = cur_word;
    if (samp_en) word_new[{lane, 3'b000} +: 8] = rdata_RAM_i;

    case (cur_op)
      OP_LB:   load_val = {{24{word_new[7]}}, word_new[7:0]};
      OP_LH:   load_val = {{16{word_new[15]}}, word_new[15:0]};
      OP_LBU:  load_val = {24'd0, word_new[7:0]};
      OP_LHU:  load_val = {16'd0, word_new[15:0]};
      default: load_val = word_new;
    endcase

    if_grant_o  = 1'b0;
    addr_RAM_o  = '0;
    wr_RAM_o    = 1'b0;
    wdata_RAM_o = 8'd0;
    if (active) begin
      addr_RAM_o = ADDR_W'(cur_base) + ADDR_W'(cur_idx);
      wr_RAM_o   = cur_store;
      if (cur_store) wdata_RAM_o = cur_sdata[{cur_idx[1:0], 3'b000} +: 8];
    end else if (rst && if_re_i) begin
      addr_RAM_o = ADDR_W'(if_addr_i);
      if_grant_o = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    op_d       = op_q;
    base_d     = base_q;
    sdata_d    = sdata_q;
    word_d     = word_q;
    wreg_d     = wreg_q;
    waddr_d    = waddr_q;
    wreg_mw_d  = wreg_mw_q;
    waddr_mw_d = waddr_mw_q;
    wdata_mw_d = wdata_mw_q;
    if (active) begin
      op_d    = cur_op;
      base_d  = cur_base;
      sdata_d = cur_sdata;
      wreg_d  = cur_wreg;
      waddr_d = cur_waddr;
      word_d  = word_new;
      cnt_d   = step_end ? '0 : cur_cnt + CW'(1);
      idx_d   = step_end ? cur_idx + 3'd1 : cur_idx;
      state_d = S_ACCESS;
      if (last) begin
        state_d    = S_IDLE;
        idx_d      = 3'd0;
        word_d     = 32'd0;
        wreg_mw_d  = cur_store ? 1'b0 : cur_wreg;
        waddr_mw_d = cur_waddr;
        wdata_mw_d = cur_store ? 32'd0 : load_val;
      end
    end else begin
      wreg_mw_d  = wreg_EXMEM_i;
      waddr_mw_d = waddr_EXMEM_i;
      wdata_mw_d = alurslt_EXMEM_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      op_q       <= 4'd0;
      base_q     <= 32'd0;
      sdata_q    <= 32'd0;
      word_q     <= 32'd0;
      wreg_q     <= 1'b0;
      waddr_q    <= 5'd0;
      wreg_mw_q  <= 1'b0;
      waddr_mw_q <= 5'd0;
      wdata_mw_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      base_q     <= base_d;
      sdata_q    <= sdata_d;
      word_q     <= word_d;
      wreg_q     <= wreg_d;
      waddr_q    <= waddr_d;
      wreg_mw_q  <= wreg_mw_d;
      waddr_mw_q <= waddr_mw_d;
      wdata_mw_q <= wdata_mw_d;
    end
  end

  assign wreg_MEMWB_o  = wreg_mw_q;
  assign waddr_MEMWB_o = waddr_mw_q;
  assign wdata_MEMWB_o = wdata_mw_q;

endmodule

// File: tb/tb_mem_stage_byte_ram.sv
// Bench for mem_stage_byte_ram: byte RAM model plus a transaction-level golden
// memory that predicts load results, latencies and write counts.
module tb_mem_stage_byte_ram;
  localparam int SD = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    aluop;
  logic          wreg_i;
  logic [4:0]    waddr_i;
  logic [31:0]   alurslt, sdata;
  logic          if_re;
  logic [31:0]   if_addr;
  logic          if_grant_o, stall_o, wr_RAM_o;
  logic [AW-1:0] addr_RAM_o;
  logic [7:0]    wdata_RAM_o, rdata_ram;
  logic          wreg_MEMWB_o;
  logic [4:0]    waddr_MEMWB_o;
  logic [31:0]   wdata_MEMWB_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];

  mem_stage_byte_ram #(.STEP_DIV(SD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .aluop_EXMEM_i(aluop), .wreg_EXMEM_i(wreg_i), .waddr_EXMEM_i(waddr_i),
    .alurslt_EXMEM_i(alurslt), .SdataBoffset_EXMEM_i(sdata),
    .if_re_i(if_re), .if_addr_i(if_addr), .if_grant_o(if_grant_o),
    .stall_o(stall_o), .addr_RAM_o(addr_RAM_o), .wr_RAM_o(wr_RAM_o),
    .wdata_RAM_o(wdata_RAM_o), .rdata_RAM_i(rdata_ram),
    .wreg_MEMWB_o(wreg_MEMWB_o), .waddr_MEMWB_o(waddr_MEMWB_o),
    .wdata_MEMWB_o(wdata_MEMWB_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : 8'h00;
  endfunction

  // Synchronous-read byte RAM seen by the DUT.
  always @(posedge clk) begin
    rdata_ram <= ram_rd(addr_RAM_o);
    if (wr_RAM_o) ram[addr_RAM_o] = wdata_RAM_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] base);
    logic [31:0] w = 0;
    for (int i = 0; i < nbytes(op); i++) w = w | (32'(gold_rd(base + 32'(i))) << (8 * i));
    case (op)
      4'd1: return {{24{w[7]}}, w[7:0]};
      4'd2: return {{16{w[15]}}, w[15:0]};
      4'd4: return {24'd0, w[7:0]};
      4'd5: return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Starts at posedge+1; drives one memory op and checks it end to end.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] base, input logic [31:0] data,
                         input logic we, input logic [4:0] wa, input logic scramble);
    int n = nbytes(op);
    int cyc = 0, st = 0, wrc = 0, bad_addr = 0, bad_gnt = 0, bad_wd = 0;
    logic store = (op >= 4'd6);
    logic [31:0] exp = store ? 32'd0 : model_load(op, base);
    logic [31:0] exp_addr;
    logic [7:0]  exp_byte;
    bit done = 0;
    aluop = op; alurslt = base; sdata = data; wreg_i = we; waddr_i = wa;
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      cyc++;
      exp_addr = base + 32'((cyc - 1) / SD);
      exp_byte = 8'(data >> (8 * ((cyc - 1) / SD)));
      if (stall_o) st++;
      if (wr_RAM_o) wrc++;
      if (addr_RAM_o !== exp_addr) bad_addr++;
      if (if_grant_o !== 1'b0) bad_gnt++;
      if (store && wdata_RAM_o !== exp_byte) bad_wd++;
      if (!stall_o) done = 1;
      else begin
        @(posedge clk); #1;
        if (scramble) begin
          aluop = 4'($urandom); alurslt = $urandom; sdata = $urandom;
          wreg_i = 1'($urandom); waddr_i = 5'($urandom);
        end
        #1;
      end
    end
    check("done", 32'(done), 32'd1);
    if (store) for (int i = 0; i < n; i++) gold[base + 32'(i)] = 8'(data >> (8 * i));
    @(posedge clk); #1;
    check("latency", cyc, n * SD);
    check("stall_cycles", st, n * SD - 1);
    check("wr_cycles", wrc, store ? n * SD : 0);
    check("addr_seq", bad_addr, 0);
    check("grant_during", bad_gnt, 0);
    if (store) check("wdata_seq", bad_wd, 0);
    check("wreg_mw", 32'(wreg_MEMWB_o), store ? 32'd0 : 32'(we));
    if (!store) begin
      check("wdata_mw", wdata_MEMWB_o, exp);
      check("waddr_mw", 32'(waddr_MEMWB_o), 32'(wa));
    end
    $display("mem op=%0d base=%h data=%h -> wreg=%b waddr=%0d wdata=%h cycles=%0d",
             op, base, data, wreg_MEMWB_o, waddr_MEMWB_o, wdata_MEMWB_o, cyc);
    aluop = 4'd0;
  endtask

  task automatic run_nonmem(input logic [3:0] op, input logic [31:0] val, input logic we,
                            input logic [4:0] wa, input logic re, input logic [31:0] fa);
    aluop = op; alurslt = val; wreg_i = we; waddr_i = wa; if_re = re; if_addr = fa;
    #1;
    check("nm_stall", 32'(stall_o), 32'd0);
    check("nm_grant", 32'(if_grant_o), 32'(re));
    check("nm_addr", addr_RAM_o, re ? fa : 32'd0);
    check("nm_wr", 32'(wr_RAM_o), 32'd0);
    @(posedge clk); #1;
    check("nm_wreg", 32'(wreg_MEMWB_o), 32'(we));
    check("nm_waddr", 32'(waddr_MEMWB_o), 32'(wa));
    check("nm_wdata", wdata_MEMWB_o, val);
    $display("alu op=%0d val=%h -> wreg=%b waddr=%0d wdata=%h", op, val,
             wreg_MEMWB_o, waddr_MEMWB_o, wdata_MEMWB_o);
  endtask

  initial begin
    rst = 1'b0; aluop = 4'd3; wreg_i = 1'b1; waddr_i = 5'd1; alurslt = 32'h10;
    sdata = 32'd0; if_re = 1'b1; if_addr = 32'h100;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_grant", 32'(if_grant_o), 32'd0);
    check("rst_addr", addr_RAM_o, 32'd0);
    check("rst_wr", 32'(wr_RAM_o), 32'd0);
    check("rst_wreg", 32'(wreg_MEMWB_o), 32'd0);
    check("rst_wdata", wdata_MEMWB_o, 32'd0);
    aluop = 4'd0; if_re = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_mem(4'd8, 32'h0, 32'h0FF00FF0, 1'b1, 5'd3, 1'b0);
    run_mem(4'd3, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0);
    run_mem(4'd1, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0);
    run_mem(4'd4, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    run_mem(4'd2, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0);
    run_mem(4'd1, 32'h1, 32'h0, 1'b1, 5'd9, 1'b0);
    run_nonmem(4'd0, 32'h12345678, 1'b1, 5'd10, 1'b0, 32'h0);
    run_nonmem(4'd0, 32'hCAFEF00D, 1'b0, 5'd11, 1'b1, 32'h100);

    // Fetch holds the port while idle, loses it for an LW, regains it afterwards.
    if_re = 1'b1; if_addr = 32'h100;
    run_mem(4'd3, 32'h0, 32'h0, 1'b1, 5'd12, 1'b1);
    #1;
    check("grant_back", 32'(if_grant_o), 32'd1);
    check("grant_addr", addr_RAM_o, 32'h100);

    // Abort an SW during its second byte; only bytes 0 and 1 reach the RAM.
    run_mem(4'd8, 32'h40, 32'h11223344, 1'b0, 5'd0, 1'b0);
    aluop = 4'd8; alurslt = 32'h40; sdata = 32'hA1B2C3D4; wreg_i = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; aluop = 4'd0;
    #1;
    check("abort_stall", 32'(stall_o), 32'd0);
    check("abort_wr", 32'(wr_RAM_o), 32'd0);
    check("abort_grant", 32'(if_grant_o), 32'd0);
    check("abort_wreg", 32'(wreg_MEMWB_o), 32'd0);
    check("abort_wdata", wdata_MEMWB_o, 32'd0);
    gold[32'h40] = 8'hD4; gold[32'h41] = 8'hC3;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_mem(4'd3, 32'h40, 32'h0, 1'b1, 5'd13, 1'b0);

    // Randomized mix, including wrap across the top of the address space.
    for (int t = 0; t < 60; t++) begin
      logic [3:0]  op   = 4'($urandom_range(0, 11));
      logic [31:0] base = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                     : 32'($urandom_range(0, 15));
      if (nbytes(op) != 0)
        run_mem(op, base, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
      else
        run_nonmem(op, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage_byte_ram.md
Name: mem_stage_byte_ram

Overview:
RISC-V MEM pipeline stage plus RAM-port control, all in one block. It executes loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a byte-wide, synchronous-read RAM, one byte per step. It stalls the pipeline while an access runs. An internal arbiter shares the single RAM port with instruction fetch, and an internal divider paces the byte steps.

Parameters:
STEP_DIV, 2, clk cycles per byte step (divider ratio, >=1)
ADDR_W, 32, RAM address width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
aluop_EXMEM_i  in  4  memory op: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
wreg_EXMEM_i  in  1  register-write enable from EX
waddr_EXMEM_i  in  5  destination register
alurslt_EXMEM_i  in  32  ALU result; byte base address for memory ops
SdataBoffset_EXMEM_i  in  32  store data
if_re_i  in  1  instruction-fetch read request
if_addr_i  in  32  fetch address
if_grant_o  out  1  fetch owns RAM port this cycle
stall_o  out  1  hold upstream pipeline
addr_RAM_o  out  ADDR_W  RAM byte address
wr_RAM_o  out  1  1 = write, 0 = read
wdata_RAM_o  out  8  RAM write byte
rdata_RAM_i  in  8  RAM read byte, valid one clk after address
wreg_MEMWB_o  out  1  writeback enable (registered)
waddr_MEMWB_o  out  5  writeback register (registered)
wdata_MEMWB_o  out  32  writeback data (registered)

Behaviour:
- Reset (rst=0, async): state IDLE, divider counter 0, all outputs 0, stall_o=0, if_grant_o=0.
- Byte count per op: byte ops N=1, halfword N=2, word N=4.
- Divider: free-running counter 0..STEP_DIV-1, restarts at 0 when an access starts. A step ends when the counter reaches STEP_DIV-1.
- Non-memory op in IDLE:
  - MEM/WB registers load wreg/waddr/alurslt next edge.
  - No stall, no RAM activity from MEM.
- Memory op in IDLE:
  - Access starts this cycle.
  - Latch op, base, store data, wreg, waddr.
  - stall_o=1 combinationally.
  - State ACCESS with index i=0.
- Load, step i:
  - addr_RAM_o = base+i, wr_RAM_o=0.
  - rdata_RAM_i is sampled on the step-end edge into byte lane i (little-endian) and refers to the previous cycle's address.
  - Hence STEP_DIV>=2 is required for loads; with STEP_DIV=1, sampling is shifted by one cycle (implementations handle this by an extra trailing step).
- Store, step i:
  - addr_RAM_o = base+i, wr_RAM_o=1 for every cycle of the step.
  - wdata_RAM_o = store byte i (bits 8i+7:8i).
  - Stores produce wreg_MEMWB_o=0.
- Completion:
  - In the final cycle of step N-1, stall_o drops to 0; upstream advances in that cycle.
  - On that edge the MEM/WB registers load the result and the state returns to IDLE.
  - Total load/store latency = N*STEP_DIV cycles, stall high for N*STEP_DIV-1 of them.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is the 4 bytes assembled.
- A memory op present in IDLE always starts a new access; back-to-back memory ops are allowed with no idle cycle.
- Address wrap: base+i wraps modulo 2^ADDR_W. No alignment requirement; misaligned accesses are legal byte sequences.
- Arbiter:
  - When MEM is ACCESS or starting, MEM drives the port and if_grant_o=0.
  - Otherwise, if if_re_i=1, then addr_RAM_o=if_addr_i, wr_RAM_o=0, if_grant_o=1.
  - Otherwise addr=0, wr=0.
  - Writes are never issued from fetch.
- While stall_o=1, input changes are ignored (values were latched).
- Reset mid-access aborts immediately: no further RAM writes, outputs 0, state IDLE.

Test Plan:
- SW, base 0, data 0x0FF00FF0, STEP_DIV=2 -> RAM writes bytes 0xF0,0x0F,0xF0,0x0F to addresses 0..3. wr_RAM_o high for 8 cycles, stall_o high 7 cycles, then wreg_MEMWB_o=0.
- After the above, LW base 0, waddr 5 -> wdata_MEMWB_o=0x0FF00FF0, waddr_MEMWB_o=5, wreg_MEMWB_o=1, 8 cycles after start.
- Same RAM contents:
  - LB base 0 -> 0xFFFFFFF0.
  - LBU base 0 -> 0x000000F0.
  - LH base 0 -> 0x00000FF0.
  - LB base 1 -> 0x0000000F.
- Non-memory op (aluop 0), alurslt 0x12345678 -> registered on next edge, stall_o never asserted.
- if_re_i=1 with if_addr_i=0x100 while idle -> if_grant_o=1, addr_RAM_o=0x100. When an LW starts, the grant drops in the same cycle and returns when stall_o falls.
- rst pulled low during the 2nd byte of SW -> bytes 2 and 3 are not written, outputs 0 immediately. After release, a new LW reads back only the updated bytes.
